// File: rtl/mem_access_unit_if.sv
// Memory port bundle between mem_access_unit (master) and a variable-latency memory (slave).
// The request side is registered in the master; ack/rdata come back as a single-cycle pulse.
interface mem_access_unit_if #(
  parameter int WIDTH = 16
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle CPU: converts FSM strobes into one req/ack access,
// holds IR/MDR, and stalls the control FSM until the access completes or times out.
module mem_access_unit #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] B,
  mem_access_unit_if.master mem,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] MDR,
  output logic [3:0]       Opcode,
  output logic             Stall,
  output logic             Err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  kind_t            kind, cmd_kind;
  logic [CNT_W-1:0] cnt;
  logic             cmd, conflict;
  logic             accept, ack_hit, abort, tick;

  assign cmd      = IRWrite | MemRead | MemWrite;
  assign conflict = (IRWrite & MemRead) | (IRWrite & MemWrite) | (MemRead & MemWrite);
  assign Opcode   = IR[3:0];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_kind   = K_FETCH;
    accept     = 1'b0;
    ack_hit    = 1'b0;
    abort      = 1'b0;
    tick       = 1'b0;
    Stall      = 1'b0;
    // Store outranks fetch, fetch outranks load; losers are dropped and flagged.
    if (MemWrite)     cmd_kind = K_STORE;
    else if (IRWrite) cmd_kind = K_FETCH;
    else if (MemRead) cmd_kind = K_LOAD;
    case (state)
      IDLE: begin
        Stall = cmd;
        if (cmd) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (mem.mem_ack) begin
          ack_hit    = 1'b1;
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          abort      = 1'b1;
          state_next = DONE;
        end else begin
          tick = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      IR            <= '0;
      MDR           <= '0;
      Err           <= 1'b0;
      cnt           <= '0;
      kind          <= K_FETCH;
    end else begin
      if (accept) begin
        mem.mem_addr  <= IorD ? ALUOut : PC;
        mem.mem_wdata <= B;
        mem.mem_we    <= MemWrite;
        mem.mem_req   <= 1'b1;
        kind          <= cmd_kind;
        cnt           <= '0;
        if (conflict) Err <= 1'b1;
      end
      // Read data is only trusted on the ack cycle of a live access.
      if (ack_hit) begin
        mem.mem_req <= 1'b0;
        cnt         <= '0;
        if (kind == K_FETCH) IR  <= mem.mem_rdata;
        if (kind == K_LOAD)  MDR <= mem.mem_rdata;
      end
      if (abort) begin
        mem.mem_req <= 1'b0;
        Err         <= 1'b1;
      end
      if (tick) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a transaction-level memory model.
module tb_mem_access_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iord = 1'b0, irwrite = 1'b0, memread = 1'b0, memwrite = 1'b0;
  logic [15:0] pc = '0, aluout = '0, b = '0;
  logic [15:0] ir, mdr;
  logic [3:0]  opcode;
  logic        stall, err;

  mem_access_unit_if #(.WIDTH(16)) bus ();

  mem_access_unit #(.WIDTH(16), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .CLK(clk), .Reset(rst_n), .IorD(iord), .IRWrite(irwrite), .MemRead(memread),
    .MemWrite(memwrite), .PC(pc), .ALUOut(aluout), .B(b), .mem(bus.master),
    .IR(ir), .MDR(mdr), .Opcode(opcode), .Stall(stall), .Err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr, wdata, ir, mdr;
    logic        we, err;
    int          busy;
  } exp_t;
  typedef struct {
    int          k;
    logic [15:0] rd;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int   vectors = 0, miscompares = 0;
  logic [15:0] ir_m = '0, mdr_m = '0;
  logic        err_m = 1'b0;
  bit          mon_en = 1'b0, force_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: acks in BUSY cycle k (k=0 never acks), stray acks while idle.
  initial begin
    bit prev;
    int left;
    rsp_t r;
    prev = 1'b0; left = 0; r.k = 0; r.rd = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'($urandom);
      if (bus.mem_req && !prev) begin
        left = 0;
        if (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          left = r.k;
        end
      end
      if (bus.mem_req && left > 0) begin
        if (left == 1) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = r.rd;
        end
        left--;
      end else if (!bus.mem_req) begin
        bus.mem_ack = ($urandom_range(0, 3) == 0);
      end
      if (force_ack) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hDEAD;
      end
      prev = bus.mem_req;
    end
  end

  // Monitor: checks request fields while busy, results on the DONE cycle, Stall always.
  initial begin
    bit prev;
    int busy;
    exp_t e;
    prev = 1'b0; busy = 0;
    forever begin
      @(negedge clk); #1;
      if (!mon_en || !rst_n) begin
        prev = 1'b0; busy = 0;
        continue;
      end
      if (bus.mem_req) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_req: got req=1 expected req=0 at %0t", $time);
        end else begin
          chk("mem_addr", bus.mem_addr, exp_q[0].addr);
          chk("mem_we", bus.mem_we, exp_q[0].we);
          chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
        end
        chk("stall_busy", stall, 1'b1);
        busy++;
      end else if (prev) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("busy_cycles", busy, e.busy);
          chk("ir", ir, e.ir);
          chk("mdr", mdr, e.mdr);
          chk("err", err, e.err);
          chk("opcode", opcode, e.ir[3:0]);
        end
        chk("stall_done", stall, 1'b0);
        busy = 0;
      end else begin
        chk("stall_idle", stall, irwrite | memread | memwrite);
      end
      prev = bus.mem_req;
    end
  end

  task automatic issue(input logic io, input logic irw, input logic mr, input logic mw,
                       input logic [15:0] p, input logic [15:0] a, input logic [15:0] bd,
                       input int k, input logic [15:0] rd);
    exp_t e;
    rsp_t r;
    bit   done;
    int   n;
    n = int'(irw) + int'(mr) + int'(mw);
    if (n > 1) err_m = 1'b1;
    e.addr  = io ? a : p;
    e.wdata = bd;
    e.we    = mw;
    if (k == 0) err_m = 1'b1;
    else if (!mw && irw) ir_m = rd;
    else if (!mw && mr) mdr_m = rd;
    e.ir = ir_m; e.mdr = mdr_m; e.err = err_m;
    e.busy = (k == 0) ? TMO : k;
    exp_q.push_back(e);
    r.k = k; r.rd = rd;
    rsp_q.push_back(r);
    @(negedge clk);
    iord = io; irwrite = irw; memread = mr; memwrite = mw; pc = p; aluout = a; b = bd;
    @(posedge clk); #1;
    irwrite = 1'b0; memread = 1'b0; memwrite = 1'b0;
    pc = 16'($urandom); aluout = 16'($urandom); b = 16'($urandom); iord = 1'($urandom);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!bus.mem_req) done = 1'b1;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL completion_timeout: got req=1 expected req=0 at %0t", $time);
    end
    // Strobes raised during DONE belong to the finished state and must be ignored.
    irwrite = 1'($urandom);
    @(posedge clk); #1;
    irwrite = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_addr", bus.mem_addr, 16'h0);
    chk("rst_wdata", bus.mem_wdata, 16'h0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_mdr", mdr, 16'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 3, 16'h1238);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0200, 16'h0000, 1, 16'hBEEF);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0300, 16'h5A5A, 2, 16'h7777);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 0, 16'h4444);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000, 2, 16'hA5C3);

    // Reset two cycles into a fetch; a late ack after release must not revive it.
    mon_en = 1'b0;
    @(negedge clk);
    iord = 1'b0; irwrite = 1'b1; pc = 16'h0040;
    @(posedge clk); #1;
    irwrite = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", bus.mem_req, 1'b0);
    chk("midrst_ir", ir, 16'h0);
    chk("midrst_mdr", mdr, 16'h0);
    chk("midrst_err", err, 1'b0);
    force_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    chk("lateack_req", bus.mem_req, 1'b0);
    chk("lateack_ir", ir, 16'h0);
    chk("lateack_stall", stall, 1'b0);
    @(posedge clk); #1;
    chk("lateack_idle_req", bus.mem_req, 1'b0);
    ir_m = '0; mdr_m = '0; err_m = 1'b0;
    rsp_q.delete();
    mon_en = 1'b1;

    issue(1'b0, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h0060, 16'h1357, 1, 16'h9999);

    for (int t = 0; t < 80; t++) begin
      logic [2:0] s;
      int k;
      s = 3'($urandom_range(1, 7));
      k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO);
      issue(1'($urandom), s[0], s[1], s[2], 16'($urandom), 16'($urandom), 16'($urandom),
            k, 16'($urandom));
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit exceeded");
  end
endmodule
